// File: rtl/pc_ctrl_if.sv
// Control-flow bundle between decode/comparator and the PC controller.
// The master drives decode and enable inputs; the slave returns PC, pulses and stats.
interface pc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             stall;
  logic             br_valid;
  logic [15:0]      br_offset;
  logic             taken;
  logic             j_valid;
  logic [25:0]      j_index;
  logic             jr_valid;
  logic [31:0]      jr_addr;
  logic [31:0]      pc;
  logic             flush;
  logic             br_pending;
  logic             addr_err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output en, stall, br_valid, br_offset, taken, j_valid, j_index, jr_valid, jr_addr,
    input  pc, flush, br_pending, addr_err, br_cnt, taken_cnt
  );

  modport slave (
    input  en, stall, br_valid, br_offset, taken, j_valid, j_index, jr_valid, jr_addr,
    output pc, flush, br_pending, addr_err, br_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch PC controller with delayed-branch resolution, j/jr redirects and
// saturating branch statistics.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input logic     clk,
  input logic     rst,
  pc_ctrl_if.slave bus
);

  typedef enum logic {FETCH, RESOLVE} state_t;

  state_t           state;
  logic [31:0]      pc_q;
  logic [31:0]      target_q;
  logic             flush_q;
  logic             addr_err_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic             advance;
  logic [31:0]      pc_inc;
  logic [31:0]      br_target;

  assign advance   = bus.en & ~bus.stall;
  assign pc_inc    = pc_q + 32'd4;
  // pc_q is already the delay-slot address when the branch sits in decode.
  assign br_target = pc_q + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc_q        <= RESET_PC;
      target_q    <= '0;
      flush_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      // Pulses last one cycle; only an advancing edge can raise them.
      flush_q    <= 1'b0;
      addr_err_q <= 1'b0;
      if (advance) begin
        unique case (state)
          FETCH: begin
            if (bus.j_valid) begin
              pc_q <= {pc_q[31:28], bus.j_index, 2'b00};
            end else if (bus.jr_valid) begin
              pc_q       <= {bus.jr_addr[31:2], 2'b00};
              addr_err_q <= |bus.jr_addr[1:0];
            end else if (bus.br_valid) begin
              target_q <= br_target;
              pc_q     <= pc_inc;
              state    <= RESOLVE;
            end else begin
              pc_q <= pc_inc;
            end
          end
          RESOLVE: begin
            if (bus.taken) begin
              pc_q    <= target_q;
              flush_q <= 1'b1;
              if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
            end else begin
              pc_q <= pc_inc;
            end
            if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
            state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.flush      = flush_q;
  assign bus.br_pending = (state == RESOLVE);
  assign bus.addr_err   = addr_err_q;
  assign bus.br_cnt     = br_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;

endmodule
